// File: rtl/ram_burst_reader_pkg.sv
// ram_burst_reader_pkg: shared beat type, FSM states and sizing helper for the burst reader
package ram_burst_reader_pkg;

    localparam int RBR_DATAW = 32;

    typedef struct packed {
        logic [RBR_DATAW-1:0] data;
        logic                 last;
    } beat_t;

    typedef enum logic {IDLE, ISSUE} state_e;

    function automatic int min_fifo_depth(input int read_latency);
        return read_latency + 1;
    endfunction

endpackage

// File: rtl/ram_burst_reader_fifo.sv
// rbr_fifo: synchronous FIFO of return beats with occupancy count
module rbr_fifo
    import ram_burst_reader_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  beat_t         din_i,
    input  logic          pop_i,
    output beat_t         dout_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    beat_t         mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          do_pop;

    function automatic logic [AW-1:0] adv(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rptr_q];
    assign count_o = count_q;
    assign empty_o = count_q == '0;
    assign full_o  = count_q == CW'(DEPTH);

    // pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wptr_q <= adv(wptr_q);
            if (do_pop) rptr_q <= adv(rptr_q);
            count_q <= count_q + CW'(push_i) - CW'(do_pop);
        end
    end

    // storage needs no reset: only entries below count are ever observed
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/ram_burst_reader.sv
// ram_burst_reader: issues burst reads to a RAM read port and returns data as a valid/ready stream
module ram_burst_reader
    import ram_burst_reader_pkg::*;
#(
    parameter int DATAW        = RBR_DATAW,
    parameter int SIZE         = 256,
    parameter int ADDRW        = SIZE > 1 ? $clog2(SIZE) : 1,
    parameter int LENW         = 8,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [ADDRW-1:0] cmd_addr_i,
    input  logic [LENW-1:0]  cmd_len_i,
    output logic             ram_read_o,
    output logic [ADDRW-1:0] ram_raddr_o,
    input  logic [DATAW-1:0] ram_rdata_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DATAW-1:0] out_data_o,
    output logic             out_last_o,
    output logic             busy_o
);

    localparam int            MIN_FIFO_DEPTH = min_fifo_depth(READ_LATENCY);
    localparam int            CW             = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_W        = FIFO_DEPTH[CW:0];

    if (READ_LATENCY != 0 && READ_LATENCY != 1) begin : g_bad_latency
        $error("READ_LATENCY must be 0 or 1");
    end
    if (FIFO_DEPTH < MIN_FIFO_DEPTH) begin : g_bad_depth
        $error("FIFO_DEPTH must be at least READ_LATENCY+1");
    end
    if (DATAW != RBR_DATAW) begin : g_bad_width
        $error("DATAW must match the beat type width");
    end

    state_e          state_q, state_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [LENW-1:0]  rem_q, rem_d;
    logic             credit, issue, push, push_last, inflight;
    logic [CW-1:0]    fifo_count;
    logic             fifo_empty, fifo_full;
    beat_t            push_beat, head;

    // buffered plus in-flight beats must fit; a same-cycle pop is deliberately not counted
    assign credit = ({1'b0, fifo_count} + {{CW{1'b0}}, inflight}) < DEPTH_W;

    // command acceptance and per-cycle address issue
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        cmd_ready_o = 1'b0;
        issue       = 1'b0;
        if (state_q == IDLE) begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
                addr_d  = cmd_addr_i;
                rem_d   = cmd_len_i;
                state_d = ISSUE;
            end
        end else if (credit) begin
            issue  = 1'b1;
            addr_d = (addr_q == ADDRW'(SIZE - 1)) ? '0 : addr_q + 1'b1;
            rem_d  = rem_q - 1'b1;
            if (rem_q == '0) state_d = IDLE;
        end
    end

    // FSM, address and remaining-beat registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    assign ram_read_o  = issue;
    assign ram_raddr_o = addr_q;

    if (READ_LATENCY == 0) begin : g_lat0
        assign push      = issue;
        assign push_last = issue && rem_q == '0;
        assign inflight  = 1'b0;
    end else begin : g_lat1
        logic vld_q, lst_q;
        // tracks the issued beat whose data the RAM returns one cycle later
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vld_q <= 1'b0;
                lst_q <= 1'b0;
            end else begin
                vld_q <= issue;
                lst_q <= issue && rem_q == '0;
            end
        end
        assign push      = vld_q;
        assign push_last = lst_q;
        assign inflight  = vld_q;
    end

    assign push_beat = '{data: ram_rdata_i, last: push_last};

    rbr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .din_i   (push_beat),
        .pop_i   (out_valid_o && out_ready_i),
        .dout_o  (head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // the credit rule makes a push into a full buffer unreachable
    always_ff @(posedge clk_i) begin
        if (rst_ni) assert (!(push && fifo_full)) else $error("push into full return buffer");
    end

    assign out_valid_o = !fifo_empty;
    assign out_data_o  = head.data;
    assign out_last_o  = !fifo_empty && head.last;
    assign busy_o      = (state_q != IDLE) || inflight || (fifo_count != '0);

endmodule

// File: tb/tb_ram_burst_reader.sv
// tb_ram_burst_reader: scoreboard bench for ram_burst_reader against a 1-cycle-latency RAM model
module tb_ram_burst_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  cmd_addr, cmd_len;
    logic        ram_read;
    logic [7:0]  ram_raddr;
    logic [31:0] ram_rdata = '0;
    logic        out_valid, out_ready, out_last, busy;
    logic [31:0] out_data;

    int checks = 0, errors = 0;
    int n_reads = 0, n_beats = 0;
    logic [32:0] exp_q[$];
    logic [7:0]  addr_q[$];
    logic [32:0] mon_e;
    logic [7:0]  mon_a;

    ram_burst_reader dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_addr_i  (cmd_addr),
        .cmd_len_i   (cmd_len),
        .ram_read_o  (ram_read),
        .ram_raddr_o (ram_raddr),
        .ram_rdata_i (ram_rdata),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input int a);
        return 32'h5A00_0000 + 32'(a * 65537);
    endfunction

    // RAM with registered output
    always @(posedge clk) if (ram_read) ram_rdata <= word(int'(ram_raddr));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: issued addresses and returned beats against queued expectations
    always @(negedge clk) if (rst_n) begin
        if (ram_read) begin
            n_reads++;
            if (addr_q.size() == 0) check("extra_read", ram_read, 1'b0);
            else begin
                mon_a = addr_q.pop_front();
                check("raddr", ram_raddr, mon_a);
            end
        end
        if (out_valid && out_ready) begin
            n_beats++;
            if (exp_q.size() == 0) check("extra_beat", out_valid, 1'b0);
            else begin
                mon_e = exp_q.pop_front();
                check("beat_data", out_data, mon_e[31:0]);
                check("beat_last", out_last, mon_e[32]);
            end
        end
    end

    task automatic send(input int a, input int len);
        logic ok;
        int t;
        for (int i = 0; i <= len; i++) begin
            addr_q.push_back(8'((a + i) % 256));
            exp_q.push_back({i == len, word((a + i) % 256)});
        end
        cmd_addr  = 8'(a);
        cmd_len   = 8'(len);
        cmd_valid = 1'b1;
        ok = 1'b0;
        t = 0;
        while (!ok && t < 50) begin
            @(negedge clk);
            ok = cmd_ready;
            t++;
        end
        check("cmd_accept", ok, 1'b1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_left"}, exp_q.size(), 0);
        check({tag, "_idle"}, busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, bad, fr, lr, fb, lb, nr, nb;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_ram_read", ram_read, 1'b0);
        check("rst_raddr", ram_raddr, 8'd0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;

        // single beat: first data two cycles after handshake
        send(5, 0);
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check("single_latency", lat, 2);
        check("single_data", out_data, word(5));
        check("single_last", out_last, 1'b1);
        check("single_busy_hold", busy, 1'b1);
        @(posedge clk);
        #1 check("single_busy_drop", busy, 1'b0);
        drain("single");

        // streaming burst
        send(0, 15);
        fr = -1; lr = -1; fb = -1; lb = -1; nr = 0; nb = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ram_read) begin
                if (fr < 0) fr = c;
                lr = c;
                nr++;
            end
            if (out_valid) begin
                if (fb < 0) fb = c;
                lb = c;
                nb++;
            end
        end
        check("stream_reads", nr, 16);
        check("stream_read_span", lr - fr, 15);
        check("stream_beats", nb, 16);
        check("stream_beat_span", lb - fb, 15);
        check("stream_first_gap", fb - fr, 2);
        drain("stream");

        // backpressure: credit limits issue to the buffer depth
        out_ready = 1'b0;
        n_reads = 0;
        send(10, 7);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (out_valid && out_data !== word(10)) bad++;
        end
        check("bp_reads", n_reads, 4);
        check("bp_stable", bad, 0);
        check("bp_valid", out_valid, 1'b1);
        check("bp_data", out_data, word(10));
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain("bp");

        // address wrap
        send(254, 3);
        drain("wrap");

        // back-to-back bursts
        send(0, 1);
        send(100, 2);
        drain("b2b");

        // reset mid-burst
        n_beats = 0;
        send(0, 9);
        lat = 0;
        while (n_beats < 3 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("mid_beats_seen", n_beats >= 3, 1'b1);
        #1 rst_n = 1'b0;
        exp_q.delete();
        addr_q.delete();
        #1 check("mid_async_valid", out_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("mid_out_valid", out_valid, 1'b0);
        check("mid_ram_read", ram_read, 1'b0);
        check("mid_cmd_ready", cmd_ready, 1'b1);
        check("mid_busy", busy, 1'b0);
        @(posedge clk);
        #1 n_beats = 0;
        send(50, 0);
        drain("post_rst");
        check("post_rst_beats", n_beats, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
